// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch PC owner, instruction-memory requester and F/D feed buffer
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        en_D,
  output logic [31:0] InstrF,
  output logic [31:0] PCplus4F,
  output logic        validF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc4   [DEPTH];

  logic push;
  logic pop;

  // Request is held with a stable address until the memory answers;
  // while waiting the buffer can only drain, so req never drops mid-request.
  assign imem_req  = !reset && (count < FULL);
  assign imem_addr = fetch_pc;

  // Redirect discards both the returning word and the consumer handshake.
  assign push = imem_req && imem_ready && !redirect;
  assign pop  = validF && en_D && !redirect;

  // Head entry is presented directly; an empty buffer shows a nop bubble.
  always_comb begin
    validF   = (count != '0);
    InstrF   = 32'h0;
    PCplus4F = 32'h0;
    if (validF) begin
      InstrF   = buf_instr[rd_ptr];
      PCplus4F = buf_pc4[rd_ptr];
    end
  end

  // Control state: reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc4[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        en_D;
  logic [31:0] InstrF;
  logic [31:0] PCplus4F;
  logic        validF;

  int checks = 0;
  int errors = 0;

  fetch_queue_unit #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .en_D(en_D),
    .InstrF(InstrF),
    .PCplus4F(PCplus4F),
    .validF(validF)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = dat(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; en_D = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, validF}, 32'd0);
    chk("rst_instr", InstrF, 32'h0);
    chk("rst_pc4", PCplus4F, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h3000);

    // steady stream, push and pop together over several pointer wraps
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stream_valid", {31'b0, validF}, 32'd1);
      chk("stream_pc4", PCplus4F, 32'h3004 + 32'(4 * k));
      chk("stream_instr", InstrF, dat(32'h3000 + 32'(4 * k)));
      chk("stream_addr", imem_addr, 32'h3004 + 32'(4 * k));
    end

    // stall 5 cycles: buffer fills, req drops, address held
    en_D = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_addr", imem_addr, 32'h3024);
      chk("stall_head", PCplus4F, 32'h3020);
    end
    en_D = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("release_valid", {31'b0, validF}, 32'd1);
      chk("release_pc4", PCplus4F, 32'h3024 + 32'(4 * j));
      chk("release_instr", InstrF, dat(32'h3020 + 32'(4 * j)));
    end

    // memory not ready for 3 cycles on 0x3000
    reset = 1'b1; imem_ready = 1'b0; en_D = 1'b0;
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h3000);
      chk("wait_valid", {31'b0, validF}, 32'd0);
      chk("wait_instr", InstrF, 32'h0);
      step();
    end
    imem_ready = 1'b1;
    step();
    chk("ready_valid", {31'b0, validF}, 32'd1);
    chk("ready_instr", InstrF, dat(32'h3000));
    chk("ready_addr", imem_addr, 32'h3004);
    step();
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_head", PCplus4F, 32'h3004);

    // redirect with two entries buffered, misaligned target
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    step();
    redirect = 1'b0;
    chk("redir_valid", {31'b0, validF}, 32'd0);
    chk("redir_instr", InstrF, 32'h0);
    chk("redir_addr", imem_addr, 32'h4000);
    imem_ready = 1'b0; en_D = 1'b1;
    step();
    chk("bubble_valid", {31'b0, validF}, 32'd0);
    chk("bubble_instr", InstrF, 32'h0);
    chk("bubble_addr", imem_addr, 32'h4000);
    imem_ready = 1'b1;
    step();
    chk("redir_pc4", PCplus4F, 32'h4004);
    chk("redir_data", InstrF, dat(32'h4000));

    // redirect while a word is being returned: that word is dropped
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    redirect = 1'b0;
    chk("drop_valid", {31'b0, validF}, 32'd0);
    chk("drop_addr", imem_addr, 32'h5000);
    step();
    chk("drop_instr", InstrF, dat(32'h5000));
    chk("drop_pc4", PCplus4F, 32'h5004);

    // reset wins over redirect
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_4000;
    step();
    reset = 1'b0; redirect = 1'b0;
    #1;
    chk("rr_addr", imem_addr, 32'h3000);
    chk("rr_valid", {31'b0, validF}, 32'd0);

    // fetch address wrap at the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc4", PCplus4F, 32'h0);
    chk("wrap_instr", InstrF, dat(32'hFFFF_FFFC));
    chk("wrap_addr1", imem_addr, 32'h0);
    step();
    chk("wrap_pc4b", PCplus4F, 32'h4);
    chk("wrap_instrb", InstrF, dat(32'h0));
    chk("wrap_addr2", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
